pacman_mover: RTL
=================

# pacman_mover

Downstream stage of the direction input controller. It consumes the registered one-hot `curr_direction` and the maze's per-tile `legal_moves`, and advances Pac-Man one pixel per `move_tick`. It maintains tile coordinates, a sub-tile pixel offset and the active heading. Its position outputs feed the renderer, pellet logic and ghost targeting.

## Interface
- `TILE_PX`, 8: pixels per tile, power of two, 4..16.
- `MAP_W`, 28: maze width in tiles.
- `MAP_H`, 31: maze height in tiles.
- `START_X`, 13: reset tile column.
- `START_Y`, 23: reset tile row.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `move_tick` in 1: one-cycle step strobe from the frame/speed timer.
- `curr_direction` in 4: requested direction, one-hot.
  - `0001` left, `0010` right, `0100` up, `1000` down.
- `legal_moves` in 4: legal exits of tile (`tile_x`, `tile_y`), same bit order.
  - Driven combinationally from the maze ROM.
  - Valid in the same cycle as the tile outputs.
- `tile_x` out 5: current tile column.
- `tile_y` out 5: current tile row.
- `offset` out 4: pixels travelled from the tile centre along `heading`, 0..TILE_PX-1.
- `heading` out 4: one-hot active direction.
- `moving` out 1: 1 while in state MOVING.
- `pixel_x` out 8: horizontal screen position, `tile_x*TILE_PX + TILE_PX/2` ± offset, modulo 256.
- `pixel_y` out 8: vertical screen position, same rule as `pixel_x`.
- `tile_entered` out 1: one-cycle pulse when a new tile centre is reached.

## Operation
- **States:** CENTER (`offset` = 0) and MOVING (`offset` ≠ 0). `moving` = (state == MOVING).
- **Valid request:** `curr_direction` is a valid request only if exactly one bit is set. 0000 and multi-hot values mean no request.
- **CENTER, on `move_tick`**, choose the first matching rule:
  - Valid request whose `legal_moves` bit is set: `heading` ← request, `offset` ← 1, go to MOVING.
  - Otherwise, `heading` legal: `offset` ← 1, go to MOVING.
  - Otherwise: stay in CENTER. `heading` is unchanged and the mover is stopped.
- **MOVING, on `move_tick`:**
  - **Reversal:** request equals the opposite of `heading`. `heading` flips, `tile` ← neighbour in the old heading, `offset` ← TILE_PX − `offset`. Screen position is unchanged and `tile_entered` stays 0.
  - **Arrival:** `offset` == TILE_PX−1. `tile` ← neighbour in `heading`, `offset` ← 0, go to CENTER, pulse `tile_entered`.
  - **Otherwise:** `offset` ← `offset` + 1.
  - Perpendicular requests are ignored until CENTER.
- **Neighbour rule:**
  - Left: x−1. Right: x+1. Up: y−1. Down: y+1.
  - Horizontal edges follow the Configuration section.
  - Vertical wrap never occurs. The maze guarantees that the up/down bits of `legal_moves` are 0 at rows 0 and MAP_H−1.
- **Pixel arithmetic:** computed in 9 bits and truncated to 8 bits. `offset` adds for right/down and subtracts for left/up.
- **Without `move_tick`:** no state changes.

## Timing
- **Reset values:** `tile_x`=START_X, `tile_y`=START_Y, `offset`=0, `heading`=0001, state CENTER, `moving`=0, `tile_entered`=0.
- **Pixel reset values:** `pixel_x`=START_X*TILE_PX+TILE_PX/2 and `pixel_y`=START_Y*TILE_PX+TILE_PX/2 (108 and 188 at the defaults).
- **Latency:** all outputs are registered and update on the edge that samples `move_tick`, one cycle after the tick is presented.
- **Sampling:** `legal_moves` and `curr_direction` are sampled in the tick cycle.
- **`tile_entered`:** high for exactly the one cycle following the arrival edge.
- **Mid-operation reset:** asserting `rst` during MOVING returns every output to its reset value immediately. `move_tick` coincident with `rst` is ignored.
- **Back-to-back ticks:** each `move_tick` on consecutive cycles advances one pixel. There is no minimum tick spacing.

## Configuration
- **`PACMAN_TUNNEL_WRAP_EN` defined:**
  - Left from `tile_x`=0 goes to MAP_W−1.
  - Right from MAP_W−1 goes to 0.
  - Pixel outputs wrap modulo 256 during the transition.
- **`PACMAN_TUNNEL_WRAP_EN` undefined:**
  - In CENTER at `tile_x`=0 with left chosen, or at MAP_W−1 with right chosen, the move is treated as illegal and the fallback rules apply, so the mover stops.
  - `tile_x` never leaves 0..MAP_W−1.

## Test plan
- **Reset:** assert `rst` → outputs equal the reset values (`pixel_x`=108, `pixel_y`=188), `moving`=0, `heading`=0001.
- **Straight run:** `legal_moves`=0011, `curr_direction`=0010, 8 ticks → `offset` goes 1..7 then 0, `tile_x`=14, one `tile_entered` pulse, `pixel_x`=116.
- **Reversal:** after 3 right ticks, request 0001 on the next tick → `heading`=0001, `tile_x`=14, `offset`=5, `pixel_x` unchanged at 111, no pulse.
- **Wall stop:** at centre with `legal_moves`=0000 and a valid request → no movement, `moving`=0, `tile_x`/`tile_y` hold.
- **Bad request:** `curr_direction`=0110 at centre with heading left legal → continues left. A perpendicular legal request mid-tile is not taken until the next centre.
- **Tunnel:** at `tile_x`=0 moving left, 8 ticks:
  - With `PACMAN_TUNNEL_WRAP_EN` defined: `tile_x`=27, `tile_entered` pulses.
  - With it undefined: stays at `tile_x`=0, `moving`=0.

Source files
------------

// File: rtl/pacman_mover_if.sv
// Mover bus: step strobe, requested direction and tile legality in; position out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the mover accepts a step on every move_tick.
//
// Modports:
//   master - upstream controller / maze side: drives move_tick, curr_direction,
//            legal_moves and observes the position outputs.
//   slave  - the mover itself.
interface pacman_mover_if;
    logic       move_tick;       // one-cycle step strobe
    logic [3:0] curr_direction;  // requested direction, one-hot {down,up,right,left}
    logic [3:0] legal_moves;     // legal exits of (tile_x, tile_y), same bit order
    logic [4:0] tile_x;          // current tile column
    logic [4:0] tile_y;          // current tile row
    logic [3:0] offset;          // pixels travelled from tile centre along heading
    logic [3:0] heading;         // one-hot active direction
    logic       moving;          // 1 while between tile centres
    logic [7:0] pixel_x;         // horizontal screen position
    logic [7:0] pixel_y;         // vertical screen position
    logic       tile_entered;    // one-cycle pulse after reaching a new centre

    modport master (
        output move_tick, curr_direction, legal_moves,
        input  tile_x, tile_y, offset, heading, moving,
               pixel_x, pixel_y, tile_entered
    );

    modport slave (
        input  move_tick, curr_direction, legal_moves,
        output tile_x, tile_y, offset, heading, moving,
               pixel_x, pixel_y, tile_entered
    );
endinterface

// File: rtl/pacman_mover.sv
// Pac-Man mover: advances one pixel per move_tick along tile-centre rails, with turn/reversal rules.
// Latency: every output is registered and reflects a tick on the edge that samples it (1 cycle).
// Backpressure: none; a tick may arrive every cycle and each one is consumed.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst    - asynchronous active-high reset
//   mv_if  - pacman_mover_if.slave: move_tick, curr_direction, legal_moves in;
//            tile_x, tile_y, offset, heading, moving, pixel_x, pixel_y, tile_entered out
//
// Build option: define PACMAN_TUNNEL_WRAP_EN to let the mover leave column 0 to the
// left (arriving at MAP_W-1) and column MAP_W-1 to the right (arriving at 0). Without
// it, those exits are treated as walls and the mover never leaves 0..MAP_W-1.
module pacman_mover #(
    parameter int TILE_PX = 8,   // pixels per tile, power of two, 4..16
    parameter int MAP_W   = 28,  // maze width in tiles
    parameter int MAP_H   = 31,  // maze height in tiles
    parameter int START_X = 13,  // reset tile column
    parameter int START_Y = 23   // reset tile row
) (
    input  logic          clk,
    input  logic          rst,
    pacman_mover_if.slave mv_if
);

    // Direction encoding shared by curr_direction, legal_moves and heading.
    localparam logic [3:0] DIR_L = 4'b0001;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_D = 4'b1000;

    localparam logic [3:0] OFF_LAST = 4'(TILE_PX - 1);
    // TILE_PX = 16 truncates to 0 here; 0 - offset still yields 16 - offset mod 16.
    localparam logic [3:0] OFF_SPAN = 4'(TILE_PX);
    localparam logic [4:0] X_MAX    = 5'(MAP_W - 1);
    localparam logic [4:0] Y_MAX    = 5'(MAP_H - 1);
    localparam logic [4:0] RST_X    = 5'(START_X);
    localparam logic [4:0] RST_Y    = 5'(START_Y);
    localparam logic [7:0] RST_PX   = 8'(START_X * TILE_PX + TILE_PX / 2);
    localparam logic [7:0] RST_PY   = 8'(START_Y * TILE_PX + TILE_PX / 2);

    typedef enum logic {
        CENTER = 1'b0,
        MOVING = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] tile_x_q, tile_x_d;
    logic [4:0] tile_y_q, tile_y_d;
    logic [3:0] offset_q, offset_d;
    logic [3:0] heading_q, heading_d;
    logic [7:0] pixel_x_q, pixel_x_d;
    logic [7:0] pixel_y_q, pixel_y_d;
    logic       tile_entered_q, tile_entered_d;

    logic [3:0] req;
    logic [3:0] legal;
    logic       req_valid;
    logic       req_ok;
    logic       hdg_ok;
    logic       is_reversal;
    logic       blocked_l;
    logic       blocked_r;
    logic [4:0] nbr_x;
    logic [4:0] nbr_y;

    function automatic logic [3:0] opposite(input logic [3:0] dir);
        // left<->right, up<->down
        return {dir[2], dir[3], dir[0], dir[1]};
    endfunction

    assign req   = mv_if.curr_direction;
    assign legal = mv_if.legal_moves;

    // Exactly one bit set; zero and multi-hot values are "no request".
    assign req_valid = (req != 4'd0) && ((req & (req - 4'd1)) == 4'd0);

    // Horizontal edge exits that must be refused at a tile centre.
    always_comb begin
        blocked_l = 1'b0;
        blocked_r = 1'b0;
`ifdef PACMAN_TUNNEL_WRAP_EN
        blocked_l = 1'b0;
        blocked_r = 1'b0;
`else
        blocked_l = (tile_x_q == 5'd0);
        blocked_r = (tile_x_q == X_MAX);
`endif
    end

    // A direction can be taken from the centre when the maze allows it and it does
    // not run off a non-wrapping horizontal edge.
    assign req_ok = req_valid
                 && ((req & legal) != 4'd0)
                 && !((req == DIR_L) && blocked_l)
                 && !((req == DIR_R) && blocked_r);

    assign hdg_ok = ((heading_q & legal) != 4'd0)
                 && !((heading_q == DIR_L) && blocked_l)
                 && !((heading_q == DIR_R) && blocked_r);

    assign is_reversal = (req == opposite(heading_q));

    // Neighbour tile along the current heading. Both arrival and reversal step the
    // tile in the heading held before the edge.
    always_comb begin
        nbr_x = tile_x_q;
        nbr_y = tile_y_q;
        case (heading_q)
            DIR_L: begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                nbr_x = (tile_x_q == 5'd0) ? X_MAX : tile_x_q - 5'd1;
`else
                nbr_x = (tile_x_q == 5'd0) ? tile_x_q : tile_x_q - 5'd1;
`endif
            end
            DIR_R: begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                nbr_x = (tile_x_q == X_MAX) ? 5'd0 : tile_x_q + 5'd1;
`else
                nbr_x = (tile_x_q == X_MAX) ? tile_x_q : tile_x_q + 5'd1;
`endif
            end
            // The maze never marks up/down legal on the outer rows; the clamps only
            // keep tile_y inside the map should that ever be violated.
            DIR_U:   nbr_y = (tile_y_q == 5'd0)  ? tile_y_q : tile_y_q - 5'd1;
            DIR_D:   nbr_y = (tile_y_q == Y_MAX) ? tile_y_q : tile_y_q + 5'd1;
            default: ;
        endcase
    end

    // Next-state / movement rules.
    always_comb begin
        state_d        = state_q;
        tile_x_d       = tile_x_q;
        tile_y_d       = tile_y_q;
        offset_d       = offset_q;
        heading_d      = heading_q;
        tile_entered_d = 1'b0;

        if (mv_if.move_tick) begin
            case (state_q)
                CENTER: begin
                    if (req_ok) begin
                        heading_d = req;
                        offset_d  = 4'd1;
                        state_d   = MOVING;
                    end else if (hdg_ok) begin
                        offset_d  = 4'd1;
                        state_d   = MOVING;
                    end
                    // else: stopped against a wall, heading kept for next time
                end
                MOVING: begin
                    if (is_reversal) begin
                        // Re-reference the position to the tile we were heading
                        // into, so the screen position does not jump.
                        heading_d = opposite(heading_q);
                        tile_x_d  = nbr_x;
                        tile_y_d  = nbr_y;
                        offset_d  = OFF_SPAN - offset_q;
                    end else if (offset_q == OFF_LAST) begin
                        tile_x_d       = nbr_x;
                        tile_y_d       = nbr_y;
                        offset_d       = 4'd0;
                        state_d        = CENTER;
                        tile_entered_d = 1'b1;
                    end else begin
                        offset_d = offset_q + 4'd1;
                    end
                end
                default: state_d = CENTER;
            endcase
        end
    end

    // Screen position from the next-state values so pixels are registered together
    // with the tile/offset they describe. 8-bit arithmetic gives the modulo-256 wrap.
    always_comb begin
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] off8;
        cx   = 8'(int'(tile_x_d) * TILE_PX + TILE_PX / 2);
        cy   = 8'(int'(tile_y_d) * TILE_PX + TILE_PX / 2);
        off8 = {4'd0, offset_d};
        pixel_x_d = cx;
        pixel_y_d = cy;
        case (heading_d)
            DIR_L:   pixel_x_d = cx - off8;
            DIR_R:   pixel_x_d = cx + off8;
            DIR_U:   pixel_y_d = cy - off8;
            DIR_D:   pixel_y_d = cy + off8;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= CENTER;
            tile_x_q       <= RST_X;
            tile_y_q       <= RST_Y;
            offset_q       <= 4'd0;
            heading_q      <= DIR_L;
            pixel_x_q      <= RST_PX;
            pixel_y_q      <= RST_PY;
            tile_entered_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tile_x_q       <= tile_x_d;
            tile_y_q       <= tile_y_d;
            offset_q       <= offset_d;
            heading_q      <= heading_d;
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            tile_entered_q <= tile_entered_d;
        end
    end

    assign mv_if.tile_x       = tile_x_q;
    assign mv_if.tile_y       = tile_y_q;
    assign mv_if.offset       = offset_q;
    assign mv_if.heading      = heading_q;
    assign mv_if.moving       = (state_q == MOVING);
    assign mv_if.pixel_x      = pixel_x_q;
    assign mv_if.pixel_y      = pixel_y_q;
    assign mv_if.tile_entered = tile_entered_q;

endmodule
